// File: rtl/adc_sampler.sv
// ADC front end: syncs JA, block-averages samples on a fixed tick and raises a ready/ack flag.
// Average lands one edge after the last tick and the rest/active flags one edge later; an unacked average gets overwritten and sets sticky overrun.
module adc_sampler #(
   parameter int          SAMPLE_DIV = 500,
   parameter int          LOG2_AVG   = 3,
   parameter logic [7:0]  HI_THRESH  = 8'd160,
   parameter logic [7:0]  LO_THRESH  = 8'd96,
   parameter int          HOLD       = 2
) (
   input  logic       clock,
   input  logic       ctrl_reset,
   input  logic [7:0] JA,
   input  logic       rd_ack,
   output logic [7:0] adc_avg,
   output logic       adc_ready,
   output logic       overrun,
   output logic       rest,
   output logic       active
);

   localparam int DW = $clog2(SAMPLE_DIV);
   localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam int AW = 8 + LOG2_AVG;
   localparam int HW = $clog2(HOLD + 1);

   localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'((1 << LOG2_AVG) - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   localparam logic [1:0] WARMUP = 2'd0;
   localparam logic [1:0] REST   = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   logic [7:0]    ja_m_q, ja_s_q;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [7:0]    avg_q, avg_d;
   logic          ready_q, ready_d;
   logic          ovr_q, ovr_d;
   logic          new_avg_q, new_avg_d;
   logic [1:0]    state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          rest_q, rest_d;
   logic          active_q, active_d;

   logic          tick;
   logic          block_done;
   logic          ack;
   logic [AW-1:0] sum;

   assign tick       = (div_q == DIV_LAST);
   assign block_done = tick && (cnt_q == CNT_LAST);
   assign ack        = rd_ack && ready_q;
   assign sum        = acc_q + AW'(ja_s_q);

   always_comb begin
      div_d     = tick ? '0 : div_q + DW'(1);
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      avg_d     = avg_q;
      ready_d   = ready_q;
      ovr_d     = ovr_q;
      new_avg_d = block_done;
      if (tick) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
         acc_d = sum;
      end
      if (block_done) begin
         acc_d   = '0;
         avg_d   = sum[LOG2_AVG +: 8];
         ready_d = 1'b1;
         // An ack in the same cycle consumes the old value, so it is not an overrun.
         if (ack)
            ovr_d = 1'b0;
         else if (ready_q)
            ovr_d = 1'b1;
      end else if (ack) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (new_avg_q) begin
         case (state_q)
            WARMUP: begin
               state_d = (avg_q >= HI_THRESH) ? ACTIVE : REST;
               hold_d  = '0;
            end
            REST: begin
               if (avg_q >= HI_THRESH) begin
                  if (hold_q == HOLD_LAST) begin
                     state_d = ACTIVE;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end else begin
                  hold_d = '0;
               end
            end
            ACTIVE: begin
               if (avg_q <= LO_THRESH) begin
                  if (hold_q == HOLD_LAST) begin
                     state_d = REST;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end else begin
                  hold_d = '0;
               end
            end
            default: begin
               state_d = WARMUP;
               hold_d  = '0;
            end
         endcase
      end
      rest_d   = (state_d == REST);
      active_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         ja_m_q    <= '0;
         ja_s_q    <= '0;
         div_q     <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         avg_q     <= '0;
         ready_q   <= 1'b0;
         ovr_q     <= 1'b0;
         new_avg_q <= 1'b0;
         state_q   <= WARMUP;
         hold_q    <= '0;
         rest_q    <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         ja_m_q    <= JA;
         ja_s_q    <= ja_m_q;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         avg_q     <= avg_d;
         ready_q   <= ready_d;
         ovr_q     <= ovr_d;
         new_avg_q <= new_avg_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         rest_q    <= rest_d;
         active_q  <= active_d;
      end
   end

   assign adc_avg   = avg_q;
   assign adc_ready = ready_q;
   assign overrun   = ovr_q;
   assign rest      = rest_q;
   assign active    = active_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with SAMPLE_DIV=4, LOG2_AVG=2, HI=160, LO=96, HOLD=2.
// Observed word is {adc_avg, adc_ready, overrun, rest, active}.
module tb_adc_sampler;

   logic       clock;
   logic       ctrl_reset;
   logic [7:0] JA;
   logic       rd_ack;
   logic [7:0] adc_avg;
   logic       adc_ready;
   logic       overrun;
   logic       rest;
   logic       active;

   logic [11:0] obs;
   logic [11:0] exp_v;
   int          n_vec;
   int          n_err;
   int          ph;

   adc_sampler #(
      .SAMPLE_DIV(4),
      .LOG2_AVG  (2),
      .HI_THRESH (8'd160),
      .LO_THRESH (8'd96),
      .HOLD      (2)
   ) dut (
      .clock     (clock),
      .ctrl_reset(ctrl_reset),
      .JA        (JA),
      .rd_ack    (rd_ack),
      .adc_avg   (adc_avg),
      .adc_ready (adc_ready),
      .overrun   (overrun),
      .rest      (rest),
      .active    (active)
   );

   assign obs = {adc_avg, adc_ready, overrun, rest, active};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ph = edges since the last tick edge; ticks fall every 4th edge after reset release.
   task automatic step();
      @(posedge clock);
      #1;
      ph = (ph == 3) ? 0 : ph + 1;
   endtask

   task automatic sample(input logic [7:0] v);
      JA = v;
      do step(); while (ph != 0);
   endtask

   task automatic apply_reset(output logic [11:0] during);
      ctrl_reset = 1'b1;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      during     = obs;
      ctrl_reset = 1'b0;
      ph         = 0;
   endtask

   task automatic test_reset();
      logic [11:0] r;
      JA = 8'd200;
      apply_reset(r);
      exp_v = 12'h000;
      if (r !== exp_v) begin
         $display("FAIL reset_state: got %h want %h", r, exp_v);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_first_average();
      sample(8'd200);
      sample(8'd200);
      sample(8'd200);
      exp_v = {8'd0, 4'b0000};
      if (obs !== exp_v) begin
         $display("FAIL t1_before_last_tick: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      sample(8'd200);
      exp_v = {8'd200, 4'b1000};
      if (obs !== exp_v) begin
         $display("FAIL t1_avg_ready: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      exp_v = {8'd200, 4'b0001};
      if (obs !== exp_v) begin
         $display("FAIL t1_warmup_to_active: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_truncation();
      logic [11:0] r;
      apply_reset(r);
      sample(8'd10);
      sample(8'd11);
      sample(8'd12);
      sample(8'd13);
      exp_v = {8'd11, 4'b1000};
      if (obs !== exp_v) begin
         $display("FAIL t2_truncated_avg: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      exp_v = {8'd11, 4'b0010};
      if (obs !== exp_v) begin
         $display("FAIL t2_warmup_to_rest: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_hysteresis();
      logic [7:0]  vals [4];
      logic [11:0] want [4];
      vals = '{8'd200, 8'd120, 8'd200, 8'd200};
      want = '{{8'd200, 4'b0010}, {8'd120, 4'b0010}, {8'd200, 4'b0010}, {8'd200, 4'b0001}};
      for (int b = 0; b < 4; b++) begin
         for (int s = 0; s < 4; s++) sample(vals[b]);
         rd_ack = 1'b1;
         step();
         rd_ack = 1'b0;
         exp_v = want[b];
         if (obs !== exp_v) begin
            $display("FAIL t3_hyst_block%0d: got %h want %h", b, obs, exp_v);
            n_err++;
         end
         n_vec++;
      end
   endtask

   task automatic test_overrun();
      for (int s = 0; s < 4; s++) sample(8'd200);
      exp_v = {8'd200, 4'b1001};
      if (obs !== exp_v) begin
         $display("FAIL t4_first_unacked: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      for (int s = 0; s < 4; s++) sample(8'd180);
      exp_v = {8'd180, 4'b1101};
      if (obs !== exp_v) begin
         $display("FAIL t4_overrun_set: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      exp_v = {8'd180, 4'b0001};
      if (obs !== exp_v) begin
         $display("FAIL t4_ack_clears: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_ack_with_new();
      // An ack while nothing is pending must change nothing.
      JA     = 8'd170;
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      exp_v = {8'd180, 4'b0001};
      if (obs !== exp_v) begin
         $display("FAIL t5_idle_ack_ignored: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      while (ph != 0) step();
      for (int s = 0; s < 3; s++) sample(8'd170);
      for (int s = 0; s < 4; s++) sample(8'd170);
      exp_v = {8'd170, 4'b1101};
      if (obs !== exp_v) begin
         $display("FAIL t5_overrun_before: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      sample(8'd100);
      sample(8'd101);
      sample(8'd102);
      JA = 8'd103;
      while (ph != 3) step();
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      exp_v = {8'd101, 4'b1001};
      if (obs !== exp_v) begin
         $display("FAIL t5_ack_on_last_tick: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      step();
      exp_v = {8'd101, 4'b1001};
      if (obs !== exp_v) begin
         $display("FAIL t5_between_thresholds: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_reset_midblock();
      logic [11:0] r;
      while (ph != 0) step();
      sample(8'd250);
      sample(8'd250);
      apply_reset(r);
      exp_v = 12'h000;
      if (r !== exp_v) begin
         $display("FAIL t6_reset_outputs: got %h want %h", r, exp_v);
         n_err++;
      end
      n_vec++;
      sample(8'd20);
      sample(8'd40);
      sample(8'd60);
      exp_v = 12'h000;
      if (obs !== exp_v) begin
         $display("FAIL t6_no_early_avg: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      sample(8'd80);
      exp_v = {8'd50, 4'b1000};
      if (obs !== exp_v) begin
         $display("FAIL t6_post_reset_avg: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
      step();
      exp_v = {8'd50, 4'b1010};
      if (obs !== exp_v) begin
         $display("FAIL t6_warmup_to_rest: got %h want %h", obs, exp_v);
         n_err++;
      end
      n_vec++;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      ph         = 0;
      ctrl_reset = 1'b1;
      JA         = 8'd0;
      rd_ack     = 1'b0;
      test_reset();
      test_first_average();
      test_truncation();
      test_hysteresis();
      test_overrun();
      test_ack_with_new();
      test_reset_midblock();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
